// File: rtl/imm_ext_pipe.sv
// Purpose: pipelined immediate extension (sign / zero / upper / shifted-sign) for decode.
// Latency: 1 cycle from accept to out_data; 1 result per cycle while out_ready is high.
// Backpressure: a 2-entry (output reg + skid) buffer; in_ready depends on state only.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_imm (IN_W) raw immediate, in_mode (2) selector
//   out_valid/out_ready output handshake; out_data (OUT_W) result, out_mode (2) its mode
// Optional: define IMM_EXT_STATS_EN to add stat_total / stat_br / stat_stall counters.
// Parameter constraints: IN_W >= 2, OUT_W > IN_W, 0 <= BR_SHIFT < OUT_W.
module imm_ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_br,
  output logic [31:0]      stat_stall
`endif
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [1:0]         out_mode_q, out_mode_d;
  logic [OUT_W-1:0]   skid_data_q, skid_data_d;
  logic [1:0]         skid_mode_q, skid_mode_d;

  logic [OUT_W-1:0]   ext_sign;
  logic [OUT_W-1:0]   ext_res;
  logic               accept;
  logic               drain;

  // Extension datapath, purely combinational from the input.
  assign ext_sign = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_res = ext_sign;
    case (in_mode)
      2'd0:    ext_res = ext_sign;
      2'd1:    ext_res = {{PAD_W{1'b0}}, in_imm};
      2'd2:    ext_res = {in_imm, {PAD_W{1'b0}}};
      default: ext_res = ext_sign << BR_SHIFT;
    endcase
  end

  // in_ready is forced low during reset so nothing is accepted into a buffer that is
  // being cleared; otherwise it depends only on occupancy, never on out_ready.
  assign in_ready  = !rst && (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

  // Next-state and datapath steering. Control decisions use only handshake bits, so an
  // X on in_imm can reach a data register but never the state register.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          out_data_d = ext_res;
          out_mode_d = in_mode;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          // Output is held by the consumer; park the new result behind it.
          state_d     = TWO;
          skid_data_d = ext_res;
          skid_mode_d = in_mode;
        end else if (accept && drain) begin
          out_data_d = ext_res;
          out_mode_d = in_mode;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // No accept possible here (in_ready=0); the skid entry is always the next one out.
        if (drain) begin
          state_d    = ONE;
          out_data_d = skid_data_q;
          out_mode_d = skid_mode_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_mode_q  <= '0;
      skid_data_q <= '0;
      skid_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [31:0] stat_total_q;
  logic [31:0] stat_br_q;
  logic [31:0] stat_stall_q;

  // Counters wrap naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_br_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept) begin
        stat_total_q <= stat_total_q + 32'd1;
      end
      if (accept && (in_mode == 2'd3)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_total = stat_total_q;
  assign stat_br    = stat_br_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (default parameters IN_W=16, OUT_W=32, BR_SHIFT=2).
// Inputs change 1ns after the rising edge; DUT outputs are sampled on the falling edge.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef IMM_EXT_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_br;
  logic [31:0] stat_stall;
`endif

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef IMM_EXT_STATS_EN
    ,
    .stat_total(stat_total),
    .stat_br   (stat_br),
    .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } sb_t;

  int          errors;
  int          checks;
  int          stall_cnt;
  sb_t         sbq[$];
  logic [31:0] cur_exp;
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference extension written with signed arithmetic rather than bit replication.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    int s;
    s = int'($signed(imm));
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'h0001_0000;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [31:0] exp);
    in_valid = v;
    in_imm   = imm;
    in_mode  = mode;
    cur_exp  = exp;
  endtask

  // Falling-edge sample: scoreboard pop on drain, push on accept, stall bookkeeping.
  task automatic sample();
    sb_t e;
    @(negedge clk);
    if (rst) begin
      sbq.delete();
      stall_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_out", out_data, 32'hxxxx_xxxx);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_mode", 32'(out_mode), 32'(e.m));
        end
      end
      if (in_valid && in_ready) begin
        e.d = cur_exp;
        e.m = in_mode;
        sbq.push_back(e);
      end
      if (in_valid && !in_ready) stall_cnt++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    stall_cnt = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 32'h0);

    vecs[0] = '{16'hF0F0, 2'd0, 32'hFFFF_F0F0};
    vecs[1] = '{16'h7900, 2'd0, 32'h0000_7900};
    vecs[2] = '{16'hF0F0, 2'd1, 32'h0000_F0F0};
    vecs[3] = '{16'h7900, 2'd2, 32'h7900_0000};
    vecs[4] = '{16'hFFFF, 2'd3, 32'hFFFF_FFFC};
    vecs[5] = '{16'h8001, 2'd3, 32'hFFFE_0004};
    vecs[6] = '{16'h8000, 2'd1, 32'h0000_8000};
    vecs[7] = '{16'h0001, 2'd2, 32'h0001_0000};

    // Reset state.
    sample();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    adv();
    rst = 1'b0;
    sample();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    adv();

    // Table vectors back to back with out_ready high: one result per cycle, in order.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].exp);
      sample();
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      if (i > 0) chk("tbl_out_valid", 32'(out_valid), 32'd1);
      adv();
    end
    drive(1'b0, 16'h0, 2'd0, 32'h0);
    sample();
    chk("tbl_last_valid", 32'(out_valid), 32'd1);
    adv();
    sample();
    chk("tbl_drained", 32'(out_valid), 32'd0);
    chk("tbl_sb_empty", 32'(sbq.size()), 32'd0);
    adv();

    // Simultaneous accept and drain in ONE for 8 cycles.
    drive(1'b1, 16'h1234, 2'd0, ref_ext(16'h1234, 2'd0));
    sample();
    adv();
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] imm;
      logic [1:0]  md;
      imm = 16'(k * 16'h1111) ^ 16'h8000;
      md  = 2'(k);
      drive(1'b1, imm, md, ref_ext(imm, md));
      sample();
      chk("one_in_ready", 32'(in_ready), 32'd1);
      chk("one_out_valid", 32'(out_valid), 32'd1);
      adv();
    end
    drive(1'b0, 16'h0, 2'd0, 32'h0);
    sample();
    adv();
    sample();
    chk("one_drained", 32'(out_valid), 32'd0);
    chk("one_sb_empty", 32'(sbq.size()), 32'd0);
    adv();

    // Reset mid-operation from TWO: stale entries must never come out.
    out_ready = 1'b0;
    drive(1'b1, 16'hABCD, 2'd1, ref_ext(16'hABCD, 2'd1));
    sample();
    adv();
    drive(1'b1, 16'h5555, 2'd3, ref_ext(16'h5555, 2'd3));
    sample();
    adv();
    drive(1'b0, 16'h0, 2'd0, 32'h0);
    sample();
    chk("two_in_ready", 32'(in_ready), 32'd0);
    adv();
    rst = 1'b1;
    sample();
    chk("rst_comb_in_ready", 32'(in_ready), 32'd0);
    adv();
    sample();
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_mode", 32'(out_mode), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    adv();
    rst = 1'b0;
    out_ready = 1'b1;
    sample();
    chk("midrst_after_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_after_valid", 32'(out_valid), 32'd0);
    adv();
    sample();
    chk("midrst_no_stale", 32'(out_valid), 32'd0);
    adv();

    // Backpressure: 1,2 accepted, 3 stalls; output held stable; drained in order.
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 2'd0, 32'h0000_0001);
    sample();
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    adv();
    drive(1'b1, 16'h0002, 2'd0, 32'h0000_0002);
    sample();
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    chk("bp_hold_a", out_data, 32'h0000_0001);
    adv();
    drive(1'b1, 16'h0003, 2'd0, 32'h0000_0003);
    for (int s = 0; s < 2; s++) begin
      sample();
      chk("bp_rdy3_low", 32'(in_ready), 32'd0);
      chk("bp_hold_b", out_data, 32'h0000_0001);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      adv();
    end
    out_ready = 1'b1;
    sample();
    chk("bp_still_full", 32'(in_ready), 32'd0);
    adv();
    sample();
    adv();
    drive(1'b0, 16'h0, 2'd0, 32'h0);
    sample();
    adv();
    sample();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sbq.size()), 32'd0);
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd3);
`ifdef IMM_EXT_STATS_EN
    chk("stat_total", stat_total, 32'd3);
    chk("stat_br", stat_br, 32'd0);
    chk("stat_stall", stat_stall, 32'(stall_cnt));
`endif
    adv();

`ifdef IMM_EXT_STATS_EN
    rst = 1'b1;
    sample();
    adv();
    rst = 1'b0;
    sample();
    chk("stat_total_clr", stat_total, 32'd0);
    chk("stat_br_clr", stat_br, 32'd0);
    chk("stat_stall_clr", stat_stall, 32'd0);
    adv();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
